// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches one instruction
// word at a time over a request/ready handshake and holds it for the control
// unit. When the control unit consumes the word, the next fetch address is
// chosen in this order: watchdog interruption, then branch, then sequential.
module instruction_fetch_unit #(
   parameter int ADDRESS_WIDTH     = 32,
   parameter int INSTRUCTION_WIDTH = 16,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR     = '0,
   parameter logic [ADDRESS_WIDTH-1:0] INTERRUPT_VECTOR = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         should_branch,
   input  logic [ADDRESS_WIDTH-1:0]     branch_target,
   input  logic                         interruption,
   input  logic                         mem_ready,
   input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
   output logic                         mem_request,
   output logic [ADDRESS_WIDTH-1:0]     mem_address,
   output logic [INSTRUCTION_WIDTH-1:0] Instruction,
   output logic                         instruction_valid,
   output logic [ADDRESS_WIDTH-1:0]     pc,
   output logic [ADDRESS_WIDTH-1:0]     return_address
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t                     state;
   state_t                     next_state;
   logic [ADDRESS_WIDTH-1:0]   fetch_pc;
   logic                       irq_pending;
   logic                       capture;
   logic                       consume;
   logic                       take_irq;
   logic [ADDRESS_WIDTH-1:0]   seq_pc;
   logic [ADDRESS_WIDTH-1:0]   target_pc;
   logic [ADDRESS_WIDTH-1:0]   next_pc;

   // State register; reset wins over everything, abandoning any fetch in flight.
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every always_ff sees the pre-edge value of every other register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: leave IDLE at once, wait for memory, wait for consume.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    next_state = FETCH;
         FETCH:   if (mem_ready) next_state = HOLD;
         HOLD:    if (enable)    next_state = FETCH;
         default: next_state = IDLE;
      endcase
   end

   // Output and next-address decode; memory strobes only matter in FETCH,
   // control-unit inputs only in HOLD.
   always_comb begin
      mem_request = (state == FETCH);
      capture     = (state == FETCH) && mem_ready;
      consume     = (state == HOLD) && enable;
      take_irq    = irq_pending || interruption;
      seq_pc      = pc + ADDRESS_WIDTH'(1);
      target_pc   = should_branch ? branch_target : seq_pc;
      next_pc     = take_irq ? INTERRUPT_VECTOR : target_pc;
   end

   assign mem_address = fetch_pc;

   // Datapath: latch fetched word, advance fetch address on consume, and track
   // a single pending interruption that is folded into the next consume.
   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_pc          <= RESET_VECTOR;
         irq_pending       <= 1'b0;
         Instruction       <= '0;
         instruction_valid <= 1'b0;
         pc                <= '0;
         return_address    <= '0;
      end else begin
         if (capture) begin
            Instruction       <= mem_data;
            pc                <= fetch_pc;
            instruction_valid <= 1'b1;
         end
         if (consume) begin
            fetch_pc          <= next_pc;
            instruction_valid <= 1'b0;
            if (take_irq) begin
               return_address <= target_pc;
               irq_pending    <= 1'b0;
            end
         end else if (interruption) begin
            irq_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a transaction-level model
// tracks the expected fetch address, presented word, pending interruption and
// saved return address while directed and randomized traffic is applied.
module tb_instruction_fetch_unit;

   localparam logic [31:0] INT_VEC = 32'd1;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        should_branch = 1'b0;
   logic [31:0] branch_target = '0;
   logic        interruption = 1'b0;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_data = '0;
   logic        mem_request;
   logic [31:0] mem_address;
   logic [15:0] Instruction;
   logic        instruction_valid;
   logic [31:0] pc;
   logic [31:0] return_address;

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0] exp_fetch;
   logic [15:0] exp_instr;
   logic [31:0] exp_pc;
   logic [31:0] exp_ret;
   bit          model_pending;

   instruction_fetch_unit dut (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .should_branch     (should_branch),
      .branch_target     (branch_target),
      .interruption      (interruption),
      .mem_ready         (mem_ready),
      .mem_data          (mem_data),
      .mem_request       (mem_request),
      .mem_address       (mem_address),
      .Instruction       (Instruction),
      .instruction_valid (instruction_valid),
      .pc                (pc),
      .return_address    (return_address)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_req"},   32'(mem_request), 32'd0);
      check({tag, "_instr"}, 32'(Instruction), 32'(exp_instr));
      check({tag, "_pc"},    pc, exp_pc);
      check({tag, "_valid"}, 32'(instruction_valid), 32'd1);
      check({tag, "_ret"},   return_address, exp_ret);
   endtask

   task automatic check_fetch(input string tag);
      check({tag, "_req"},   32'(mem_request), 32'd1);
      check({tag, "_addr"},  mem_address, exp_fetch);
      check({tag, "_instr"}, 32'(Instruction), 32'(exp_instr));
      check({tag, "_valid"}, 32'(instruction_valid), 32'd0);
      check({tag, "_ret"},   return_address, exp_ret);
   endtask

   // One full instruction: fetch (with wait states), hold (with stall), consume.
   // Entered and left with the DUT in FETCH. Directed mode fixes every choice.
   task automatic do_instr(input bit directed, input bit d_br, input logic [31:0] d_tgt,
                           input bit d_irq, input bit d_early_irq,
                           input int d_wait, input int d_stall);
      int          w;
      int          s;
      bit          pulse;
      bit          br;
      bit          irq;
      logic [31:0] tgt;
      logic [31:0] t;
      logic [15:0] data;
      w = directed ? d_wait  : int'($urandom_range(0, 3));
      s = directed ? d_stall : int'($urandom_range(0, 3));
      for (int i = 0; i < w; i++) begin
         mem_ready    = 1'b0;
         mem_data     = 16'($urandom);
         pulse        = directed ? 1'b0 : ($urandom_range(0, 7) == 0);
         interruption = pulse;
         step();
         if (pulse) model_pending = 1'b1;
         check_fetch("wait");
      end
      data         = 16'($urandom);
      mem_ready    = 1'b1;
      mem_data     = data;
      pulse        = directed ? d_early_irq : ($urandom_range(0, 7) == 0);
      interruption = pulse;
      step();
      mem_ready    = 1'b0;
      interruption = 1'b0;
      if (pulse) model_pending = 1'b1;
      exp_instr = data;
      exp_pc    = exp_fetch;
      check_hold("got");
      for (int i = 0; i < s; i++) begin
         enable       = 1'b0;
         mem_ready    = directed ? 1'b0 : 1'($urandom_range(0, 1));
         mem_data     = 16'($urandom);
         should_branch = 1'($urandom_range(0, 1));
         branch_target = $urandom;
         pulse        = directed ? 1'b0 : ($urandom_range(0, 7) == 0);
         interruption = pulse;
         step();
         if (pulse) model_pending = 1'b1;
         check_hold("stall");
      end
      br  = directed ? d_br  : 1'($urandom_range(0, 1));
      tgt = directed ? d_tgt : ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom);
      irq = directed ? d_irq : ($urandom_range(0, 5) == 0);
      enable        = 1'b1;
      should_branch = br;
      branch_target = tgt;
      interruption  = irq;
      mem_ready     = 1'b0;
      step();
      enable        = 1'b0;
      should_branch = 1'b0;
      interruption  = 1'b0;
      t = br ? tgt : exp_pc + 32'd1;
      if (model_pending || irq) begin
         exp_fetch     = INT_VEC;
         exp_ret       = t;
         model_pending = 1'b0;
      end else begin
         exp_fetch = t;
      end
      check_fetch("next");
   endtask

   task automatic model_reset();
      exp_fetch     = 32'd0;
      exp_instr     = 16'd0;
      exp_pc        = 32'd0;
      exp_ret       = 32'd0;
      model_pending = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req"},   32'(mem_request), 32'd0);
      check({tag, "_addr"},  mem_address, 32'd0);
      check({tag, "_instr"}, 32'(Instruction), 32'd0);
      check({tag, "_valid"}, 32'(instruction_valid), 32'd0);
      check({tag, "_pc"},    pc, 32'd0);
      check({tag, "_ret"},   return_address, 32'd0);
   endtask

   initial begin
      model_reset();
      reset = 1'b0;
      step();
      step();
      check_reset("rst");
      reset = 1'b1;
      step();
      check("start_req",  32'(mem_request), 32'd1);
      check("start_addr", mem_address, 32'd0);

      // linear fetch, wait states on address 2, stall then branch at pc=5
      do_instr(1, 0, 0, 0, 0, 0, 0);                 // 0
      do_instr(1, 0, 0, 0, 0, 0, 0);                 // 1
      do_instr(1, 0, 0, 0, 0, 3, 0);                 // 2, three wait states
      do_instr(1, 0, 0, 0, 0, 0, 0);                 // 3
      do_instr(1, 0, 0, 0, 0, 0, 0);                 // 4
      do_instr(1, 1, 32'h40, 0, 0, 0, 4);            // 5 -> 0x40 after stall
      do_instr(1, 1, 32'd7, 0, 0, 0, 0);             // 0x40 -> 7
      do_instr(1, 0, 0, 0, 1, 0, 0);                 // 7, irq during fetch -> 1, ret 8
      check("pend_ret", return_address, 32'd8);
      do_instr(1, 0, 0, 0, 0, 0, 0);                 // 1 -> 2 sequential
      check("seq_after_irq", mem_address, 32'd2);
      do_instr(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);     // 2 -> all-ones
      do_instr(1, 1, 32'h20, 1, 0, 0, 0);            // irq + branch at wrap point
      check("wrap_br_ret", return_address, 32'h20);
      do_instr(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);     // 1 -> all-ones
      do_instr(1, 0, 0, 1, 0, 0, 0);                 // irq, sequential wraps to 0
      check("wrap_seq_ret", return_address, 32'd0);

      // randomized traffic
      for (int n = 0; n < 200; n++) do_instr(0, 0, 0, 0, 0, 0, 0);

      // reset while a fetch is outstanding
      mem_ready = 1'b0;
      reset     = 1'b0;
      step();
      model_reset();
      check_reset("midrst");
      reset = 1'b1;
      step();
      check("restart_req",  32'(mem_request), 32'd1);
      check("restart_addr", mem_address, 32'd0);
      for (int n = 0; n < 20; n++) do_instr(0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
